// File: rtl/usb_fifo_write_arbiter_pkg.sv
// Shared types and constants for the two-requester USB data FIFO write arbiter.
package usb_fifo_write_arbiter_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned TCNT_W = 12;
    localparam int unsigned GNT_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2
    } state_t;

    localparam logic [TCNT_W-1:0] TIMEOUT_CYCLES_DEFAULT = 12'd4000;
    localparam logic [DATA_W-1:0] ABORT_WORD_DEFAULT     = 16'hFFAB;

    // Framing words emitted by the SCurve requesters
    localparam logic [DATA_W-1:0] SCURVE_HEADER = 16'h5343;
    localparam logic [DATA_W-1:0] SCURVE_TAIL   = 16'hFF45;

    typedef struct packed {
        logic              wr_en;
        logic [DATA_W-1:0] wr_din;
        logic              abort;
    } fifo_wr_t;

endpackage

// File: rtl/usb_fifo_write_arbiter.sv
// Packet-atomic round-robin arbiter feeding two requesters into one USB data FIFO,
// with an idle timeout that terminates a stalled packet with an abort word.
module usb_fifo_write_arbiter
    import usb_fifo_write_arbiter_pkg::*;
#(
    parameter logic [TCNT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter logic [DATA_W-1:0] ABORT_WORD     = ABORT_WORD_DEFAULT
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    input  logic              usb_data_fifo_full,
    output logic              usb_data_fifo_wr_en,
    output logic [DATA_W-1:0] usb_data_fifo_wr_din,
    output logic [GNT_W-1:0]  grant,
    output logic              abort_pulse
);

    state_t             state;
    state_t             state_nxt;
    logic [GNT_W-1:0]   grant_nxt;
    logic               last_served;
    logic               last_served_nxt;
    logic [TCNT_W-1:0]  tcnt;
    logic [TCNT_W-1:0]  tcnt_nxt;
    fifo_wr_t           wr_q;
    fifo_wr_t           wr_nxt;

    logic               xfer_rdy;
    logic               g_valid;
    logic [DATA_W-1:0]  g_data;
    logic               g_last;
    logic               accept;

    // Mux of the currently granted requester
    assign g_valid = grant[1] ? req1_valid : req0_valid;
    assign g_data  = grant[1] ? req1_data  : req0_data;
    assign g_last  = grant[1] ? req1_last  : req0_last;

    // Readies are forced low while reset is held, even before the state register clears
    assign xfer_rdy   = (state == XFER) && !usb_data_fifo_full && !reset;
    assign req0_ready = xfer_rdy && grant[0];
    assign req1_ready = xfer_rdy && grant[1];
    assign accept     = g_valid && xfer_rdy && (grant != '0);

    always_ff @(posedge Clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            grant       <= '0;
            last_served <= 1'b1;
            tcnt        <= '0;
            wr_q        <= '0;
        end else begin
            grant       <= grant_nxt;
            last_served <= last_served_nxt;
            tcnt        <= tcnt_nxt;
            wr_q        <= wr_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        last_served_nxt = last_served;
        tcnt_nxt        = tcnt;
        wr_nxt          = '0;

        case (state)
            IDLE: begin
                tcnt_nxt = '0;
                // On a tie the requester not served last wins
                if (req0_valid && (!req1_valid || last_served)) begin
                    grant_nxt = 2'b01;
                    state_nxt = XFER;
                end else if (req1_valid) begin
                    grant_nxt = 2'b10;
                    state_nxt = XFER;
                end
            end

            XFER: begin
                if (accept) begin
                    wr_nxt.wr_en  = 1'b1;
                    wr_nxt.wr_din = g_data;
                    tcnt_nxt      = '0;
                    if (g_last) begin
                        last_served_nxt = grant[1];
                        grant_nxt       = '0;
                        state_nxt       = IDLE;
                    end
                end else if (tcnt == TIMEOUT_CYCLES) begin
                    state_nxt = ABORT;
                end else if (!usb_data_fifo_full && !g_valid) begin
                    tcnt_nxt = tcnt + TCNT_W'(1);
                end
            end

            ABORT: begin
                if (!usb_data_fifo_full) begin
                    wr_nxt.wr_en    = 1'b1;
                    wr_nxt.wr_din   = ABORT_WORD;
                    wr_nxt.abort    = 1'b1;
                    last_served_nxt = grant[1];
                    grant_nxt       = '0;
                    state_nxt       = IDLE;
                end
            end

            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign usb_data_fifo_wr_en  = wr_q.wr_en;
    assign usb_data_fifo_wr_din = wr_q.wr_din;
    assign abort_pulse          = wr_q.abort;

endmodule
